// File: rtl/dragster_line_buffer.sv
// Ping-pong line buffer: captures pixel lines into two banks and streams each
// committed line out over an AXI-Stream master with tlast on the final pixel.
module dragster_line_buffer #(
    parameter int LINE_LENGTH = 1024,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  pixelClock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] pixelData,
    input  logic                  pixelValid,
    input  logic                  lineCaptured,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [15:0]           droppedLines,
    output logic                  busy
);
    localparam int AW = $clog2(LINE_LENGTH);
    localparam logic [AW:0] LL  = (AW+1)'(LINE_LENGTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} rd_state_t;

    logic [DATA_WIDTH-1:0] mem_a [LINE_LENGTH];
    logic [DATA_WIDTH-1:0] mem_b [LINE_LENGTH];

    logic [1:0]  full, full_next;
    logic [AW:0] len_a, len_b, cur_len;
    logic        wr_bank, blocked;
    logic [AW:0] wr_count, line_len;
    rd_state_t   state;
    logic        rd_bank;
    logic [AW:0] rd_addr;
    logic [AW-1:0] rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic        store, commit, accept, bank_done, other_free;

    always_comb begin
        store      = enable && pixelValid && !blocked && (wr_count < LL);
        line_len   = wr_count + {{AW{1'b0}}, store};
        commit     = enable && lineCaptured && !blocked && (line_len != '0);
        accept     = m_axis_tvalid && m_axis_tready;
        bank_done  = (state == R_STREAM) && accept && m_axis_tlast;
        // A bank released on this edge already counts as free for the commit.
        other_free = !full[~wr_bank] || (bank_done && (rd_bank == ~wr_bank));
        full_next  = full;
        if (bank_done) full_next[rd_bank] = 1'b0;
        if (commit)    full_next[wr_bank] = 1'b1;
        cur_len = rd_bank ? len_b : len_a;
        rd_idx  = (state == R_FETCH) ? '0 : rd_addr[AW-1:0];
        rd_word = rd_bank ? mem_b[rd_idx] : mem_a[rd_idx];
    end

    always_ff @(posedge pixelClock) begin
        if (store) begin
            if (wr_bank) mem_b[wr_count[AW-1:0]] <= pixelData;
            else         mem_a[wr_count[AW-1:0]] <= pixelData;
        end
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            wr_count     <= '0;
            wr_bank      <= 1'b0;
            blocked      <= 1'b0;
            droppedLines <= '0;
            len_a        <= '0;
            len_b        <= '0;
        end else if (!enable) begin
            wr_count <= '0;
        end else if (blocked) begin
            // Leave only on a line boundary so no partial line is ever stored.
            if (lineCaptured) begin
                if (droppedLines != '1) droppedLines <= droppedLines + 16'd1;
                if (!full[~wr_bank]) begin
                    blocked  <= 1'b0;
                    wr_bank  <= ~wr_bank;
                    wr_count <= '0;
                end
            end
        end else if (lineCaptured) begin
            wr_count <= '0;
            if (commit) begin
                if (wr_bank) len_b <= line_len;
                else         len_a <= line_len;
                if (other_free) wr_bank <= ~wr_bank;
                else            blocked <= 1'b1;
            end
        end else if (store) begin
            wr_count <= wr_count + ONE;
        end
    end

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state         <= R_IDLE;
            rd_bank       <= 1'b0;
            rd_addr       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            full          <= '0;
            busy          <= 1'b0;
        end else begin
            full <= full_next;
            busy <= |full_next;
            case (state)
                R_IDLE: begin
                    if (full[0]) begin
                        rd_bank <= 1'b0;
                        state   <= R_FETCH;
                    end else if (full[1]) begin
                        rd_bank <= 1'b1;
                        state   <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    m_axis_tdata  <= rd_word;
                    m_axis_tlast  <= (cur_len == ONE);
                    m_axis_tvalid <= 1'b1;
                    rd_addr       <= ONE;
                    state         <= R_STREAM;
                end
                R_STREAM: begin
                    if (accept) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            if (full[~rd_bank]) begin
                                rd_bank <= ~rd_bank;
                                state   <= R_FETCH;
                            end else begin
                                state <= R_IDLE;
                            end
                        end else begin
                            m_axis_tdata <= rd_word;
                            m_axis_tlast <= (rd_addr == cur_len - ONE);
                            rd_addr      <= rd_addr + ONE;
                        end
                    end
                end
                default: state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dragster_line_buffer.sv
// Directed testbench for dragster_line_buffer (LINE_LENGTH=16, DATA_WIDTH=8).
module tb_dragster_line_buffer;
    logic       pixelClock = 1'b0;
    logic       reset, enable, pixelValid, lineCaptured, m_axis_tready;
    logic [7:0] pixelData;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid, m_axis_tlast, busy;
    logic [15:0] droppedLines;

    int checks = 0;
    int passed = 0;

    logic [7:0] got_data [32];
    logic       got_last [32];
    int         got_n;

    dragster_line_buffer #(.LINE_LENGTH(16), .DATA_WIDTH(8)) dut (
        .pixelClock(pixelClock), .reset(reset), .enable(enable),
        .pixelData(pixelData), .pixelValid(pixelValid), .lineCaptured(lineCaptured),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .droppedLines(droppedLines), .busy(busy)
    );

    always #5 pixelClock = ~pixelClock;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Inputs change on negedge; the task returns on the negedge after the commit edge.
    task automatic send_line(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge pixelClock);
            pixelValid   = 1'b1;
            pixelData    = base + 8'(i);
            lineCaptured = (i == n - 1);
        end
        @(negedge pixelClock);
        pixelValid   = 1'b0;
        lineCaptured = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (m_axis_tvalid) begin
                ok = 1'b1;
                break;
            end
            @(negedge pixelClock);
        end
    endtask

    task automatic capture(input int budget, output bit done);
        done = 1'b0;
        got_n = 0;
        m_axis_tready = 1'b1;
        for (int c = 0; c < budget; c++) begin
            if (m_axis_tvalid) begin
                if (got_n < 32) begin
                    got_data[got_n] = m_axis_tdata;
                    got_last[got_n] = m_axis_tlast;
                end
                got_n++;
                if (m_axis_tlast) begin
                    done = 1'b1;
                    break;
                end
            end
            @(negedge pixelClock);
        end
        if (done) @(negedge pixelClock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge pixelClock);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, droppedLines} !== 27'd0) begin
            $display("FAIL reset_state got v=%b l=%b busy=%b d=%h drop=%0d exp all zero",
                     m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, droppedLines);
        end else passed++;
        reset = 1'b0;
        repeat (2) @(negedge pixelClock);
        checks++;
        if ({m_axis_tvalid, busy} !== 2'b00) begin
            $display("FAIL reset_idle got v=%b busy=%b exp 0 0", m_axis_tvalid, busy);
        end else passed++;
    endtask

    task automatic test_basic();
        m_axis_tready = 1'b1;
        send_line(8'h10, 4);
        checks++;
        if ({m_axis_tvalid, busy} !== 2'b01) begin
            $display("FAIL basic_commit got v=%b busy=%b exp v=0 busy=1", m_axis_tvalid, busy);
        end else passed++;
        @(negedge pixelClock);
        checks++;
        if (m_axis_tvalid !== 1'b0) begin
            $display("FAIL basic_latency1 got v=%b exp 0", m_axis_tvalid);
        end else passed++;
        for (int k = 0; k < 4; k++) begin
            @(negedge pixelClock);
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, k == 3, 8'h10 + 8'(k)}) begin
                $display("FAIL basic_beat%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         k, m_axis_tvalid, m_axis_tlast, m_axis_tdata, k == 3, 8'h10 + 8'(k));
            end else passed++;
        end
        @(negedge pixelClock);
        checks++;
        if ({m_axis_tvalid, busy} !== 2'b00) begin
            $display("FAIL basic_done got v=%b busy=%b exp 0 0", m_axis_tvalid, busy);
        end else passed++;
    endtask

    task automatic test_backpressure();
        bit ok;
        int idx;
        int stalls;
        m_axis_tready = 1'b1;
        send_line(8'h20, 8);
        wait_valid(10, ok);
        checks++;
        if (!ok) $display("FAIL bp_start got no tvalid exp tvalid within 10 cycles");
        else passed++;
        idx = 0;
        stalls = 0;
        for (int c = 0; c < 40 && idx < 8; c++) begin
            checks++;
            if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata} !== {1'b1, idx == 7, 8'h20 + 8'(idx)}) begin
                $display("FAIL bp_beat%0d got v=%b l=%b d=%h exp v=1 l=%b d=%h",
                         idx, m_axis_tvalid, m_axis_tlast, m_axis_tdata, idx == 7, 8'h20 + 8'(idx));
            end else passed++;
            if (idx == 3 && stalls < 5) begin
                m_axis_tready = 1'b0;
                stalls++;
            end else begin
                m_axis_tready = 1'b1;
                idx++;
            end
            @(negedge pixelClock);
        end
        checks++;
        if ({idx == 8, m_axis_tvalid, busy} !== 3'b100) begin
            $display("FAIL bp_end got beats=%0d v=%b busy=%b exp beats=8 v=0 busy=0",
                     idx, m_axis_tvalid, busy);
        end else passed++;
    endtask

    task automatic test_overflow();
        bit done;
        m_axis_tready = 1'b1;
        send_line(8'h40, 20);
        capture(60, done);
        checks++;
        if ({done, got_n == 16} !== 2'b11) begin
            $display("FAIL ovf_count got done=%b beats=%0d exp done=1 beats=16", done, got_n);
        end else passed++;
        for (int i = 0; i < got_n && i < 32; i++) begin
            checks++;
            if ({got_last[i], got_data[i]} !== {i == 15, 8'h40 + 8'(i)}) begin
                $display("FAIL ovf_beat%0d got l=%b d=%h exp l=%b d=%h",
                         i, got_last[i], got_data[i], i == 15, 8'h40 + 8'(i));
            end else passed++;
        end
    endtask

    task automatic test_back_to_back();
        bit done;
        bit seen;
        m_axis_tready = 1'b0;
        send_line(8'h60, 8);
        send_line(8'h70, 8);
        send_line(8'h80, 8);
        checks++;
        if ({droppedLines, busy, m_axis_tvalid, m_axis_tdata} !== {16'd1, 1'b1, 1'b1, 8'h60}) begin
            $display("FAIL b2b_blocked got drop=%0d busy=%b v=%b d=%h exp drop=1 busy=1 v=1 d=60",
                     droppedLines, busy, m_axis_tvalid, m_axis_tdata);
        end else passed++;
        capture(40, done);
        checks++;
        if ({done, got_n == 8} !== 2'b11) begin
            $display("FAIL b2b_line1_count got done=%b beats=%0d exp done=1 beats=8", done, got_n);
        end else passed++;
        for (int i = 0; i < got_n && i < 32; i++) begin
            checks++;
            if ({got_last[i], got_data[i]} !== {i == 7, 8'h60 + 8'(i)}) begin
                $display("FAIL b2b_line1_beat%0d got l=%b d=%h exp l=%b d=%h",
                         i, got_last[i], got_data[i], i == 7, 8'h60 + 8'(i));
            end else passed++;
        end
        capture(40, done);
        checks++;
        if ({done, got_n == 8} !== 2'b11) begin
            $display("FAIL b2b_line2_count got done=%b beats=%0d exp done=1 beats=8", done, got_n);
        end else passed++;
        for (int i = 0; i < got_n && i < 32; i++) begin
            checks++;
            if ({got_last[i], got_data[i]} !== {i == 7, 8'h70 + 8'(i)}) begin
                $display("FAIL b2b_line2_beat%0d got l=%b d=%h exp l=%b d=%h",
                         i, got_last[i], got_data[i], i == 7, 8'h70 + 8'(i));
            end else passed++;
        end
        // Still blocked: the next line is consumed as the exit drop.
        send_line(8'h90, 4);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (m_axis_tvalid) seen = 1'b1;
            @(negedge pixelClock);
        end
        checks++;
        if ({seen, droppedLines} !== {1'b0, 16'd2}) begin
            $display("FAIL b2b_exit got stream=%b drop=%0d exp stream=0 drop=2", seen, droppedLines);
        end else passed++;
        send_line(8'hA0, 3);
        capture(40, done);
        checks++;
        if ({done, got_n == 3} !== 2'b11) begin
            $display("FAIL b2b_after_count got done=%b beats=%0d exp done=1 beats=3", done, got_n);
        end else passed++;
        for (int i = 0; i < got_n && i < 32; i++) begin
            checks++;
            if ({got_last[i], got_data[i]} !== {i == 2, 8'hA0 + 8'(i)}) begin
                $display("FAIL b2b_after_beat%0d got l=%b d=%h exp l=%b d=%h",
                         i, got_last[i], got_data[i], i == 2, 8'hA0 + 8'(i));
            end else passed++;
        end
    endtask

    task automatic test_empty_enable();
        bit done;
        bit seen;
        m_axis_tready = 1'b1;
        @(negedge pixelClock);
        lineCaptured = 1'b1;
        @(negedge pixelClock);
        lineCaptured = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge pixelClock);
            pixelValid = 1'b1;
            pixelData  = 8'hE0 + 8'(i);
        end
        @(negedge pixelClock);
        pixelValid = 1'b0;
        enable     = 1'b0;
        @(negedge pixelClock);
        enable = 1'b1;
        @(negedge pixelClock);
        lineCaptured = 1'b1;
        @(negedge pixelClock);
        lineCaptured = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (m_axis_tvalid || busy) seen = 1'b1;
            @(negedge pixelClock);
        end
        checks++;
        if ({seen, droppedLines} !== {1'b0, 16'd2}) begin
            $display("FAIL empty_enable got activity=%b drop=%0d exp activity=0 drop=2",
                     seen, droppedLines);
        end else passed++;
        send_line(8'hB0, 5);
        capture(40, done);
        checks++;
        if ({done, got_n == 5} !== 2'b11) begin
            $display("FAIL empty_next_count got done=%b beats=%0d exp done=1 beats=5", done, got_n);
        end else passed++;
        for (int i = 0; i < got_n && i < 32; i++) begin
            checks++;
            if ({got_last[i], got_data[i]} !== {i == 4, 8'hB0 + 8'(i)}) begin
                $display("FAIL empty_next_beat%0d got l=%b d=%h exp l=%b d=%h",
                         i, got_last[i], got_data[i], i == 4, 8'hB0 + 8'(i));
            end else passed++;
        end
    endtask

    task automatic test_reset_mid_stream();
        bit ok;
        bit done;
        m_axis_tready = 1'b0;
        send_line(8'hC0, 4);
        wait_valid(10, ok);
        checks++;
        if (!ok) $display("FAIL rst_mid_start got no tvalid exp tvalid within 10 cycles");
        else passed++;
        reset = 1'b1;
        @(negedge pixelClock);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, droppedLines} !== 27'd0) begin
            $display("FAIL rst_mid_state got v=%b l=%b busy=%b d=%h drop=%0d exp all zero",
                     m_axis_tvalid, m_axis_tlast, busy, m_axis_tdata, droppedLines);
        end else passed++;
        reset = 1'b0;
        m_axis_tready = 1'b1;
        send_line(8'hD0, 4);
        capture(40, done);
        checks++;
        if ({done, got_n == 4} !== 2'b11) begin
            $display("FAIL rst_mid_count got done=%b beats=%0d exp done=1 beats=4", done, got_n);
        end else passed++;
        for (int i = 0; i < got_n && i < 32; i++) begin
            checks++;
            if ({got_last[i], got_data[i]} !== {i == 3, 8'hD0 + 8'(i)}) begin
                $display("FAIL rst_mid_beat%0d got l=%b d=%h exp l=%b d=%h",
                         i, got_last[i], got_data[i], i == 3, 8'hD0 + 8'(i));
            end else passed++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable        = 1'b1;
        pixelValid    = 1'b0;
        lineCaptured  = 1'b0;
        pixelData     = 8'h00;
        m_axis_tready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_back_to_back();
        test_empty_enable();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/dragster_line_buffer.md
DRAGSTER_LINE_BUFFER -- requirements
Module: dragster_line_buffer

Interface
REQ-001 SHALL have parameter LINE_LENGTH, default 1024, maximum pixels stored per line (power of two, 16..4096).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-003 SHALL have port pixelClock  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  write-side enable; low means ignore pixelValid and lineCaptured.
REQ-006 SHALL have port pixelData  input  DATA_WIDTH  pixel from the capture unit.
REQ-007 SHALL have port pixelValid  input  1  pixelData valid this cycle.
REQ-008 SHALL have port lineCaptured  input  1  one-cycle end-of-line pulse from the capture unit.
REQ-009 SHALL have port m_axis_tdata  output  DATA_WIDTH  streamed pixel.
REQ-010 SHALL have port m_axis_tvalid  output  1  stream valid.
REQ-011 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-012 SHALL have port m_axis_tlast  output  1  marks the last pixel of a line.
REQ-013 SHALL have port droppedLines  output  16  count of discarded lines, saturating at 0xFFFF.
REQ-014 SHALL have port busy  output  1  high while either bank is full or being streamed.

Function
REQ-015 SHALL hold two banks (A, B) of LINE_LENGTH x DATA_WIDTH with synchronous one-cycle read; write bank after reset is A.
REQ-016 Write side SHALL store pixelData at wrCount in the write bank on each pixelValid with enable high and wrCount < LINE_LENGTH, then increment wrCount.
REQ-017 Pixels arriving at wrCount = LINE_LENGTH SHALL be discarded; the line still commits with length LINE_LENGTH.
REQ-018 pixelValid and lineCaptured in the same cycle SHALL store that pixel as the last pixel of the line.
REQ-019 On lineCaptured with wrCount (including same-cycle pixel) > 0: bank SHALL be marked full with stored length; wrCount cleared; write bank switches to the other bank if it is free.
REQ-020 lineCaptured with zero pixels SHALL be ignored: no commit, no drop count.
REQ-021 If the other bank is not free at commit, write side SHALL enter BLOCKED: pixels discarded, each lineCaptured increments droppedLines.
REQ-022 BLOCKED SHALL exit only on the lineCaptured after the other bank became free, so no partial line is ever stored; that pulse counts as a drop and wrCount restarts at 0 on the free bank.
REQ-023 Bank release and commit in the same cycle SHALL treat the releasing bank as free.
REQ-024 enable low SHALL discard the partial line (wrCount cleared) without counting a drop; read side unaffected.
REQ-025 Read FSM states: R_IDLE, R_FETCH, R_STREAM.
REQ-026 R_IDLE -> R_FETCH when any bank is full; A before B if both full; oldest-committed first thereafter (banks strictly alternate).
REQ-027 R_FETCH SHALL issue address 0 for one cycle; R_STREAM SHALL assert m_axis_tvalid in the next cycle, i.e. tvalid rises 2 cycles after the commit edge.
REQ-028 In R_STREAM, m_axis_tdata/tlast SHALL remain stable while tvalid high and tready low; the next pixel is presented the cycle after each accepted beat (tvalid && tready) with no bubble (prefetch).
REQ-029 m_axis_tlast SHALL be high exactly on pixel index length-1; after that beat is accepted the bank is freed and FSM returns to R_IDLE (or R_FETCH if the other bank is full).
REQ-030 busy SHALL equal OR of both bank full/streaming flags, registered.

Reset
REQ-031 reset SHALL clear: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, droppedLines=0, busy=0, both banks free, wrCount=0, write bank=A, read FSM R_IDLE, BLOCKED cleared.
REQ-032 reset mid-line or mid-stream SHALL abandon all buffered data; bank memory contents need not be cleared.

Verification
REQ-033 Reset, enable=1, 4 pixels 0x10..0x13, lineCaptured on the 4th, tready=1 -> tvalid 2 cycles later, beats 0x10,0x11,0x12,0x13, tlast on 0x13 only, busy falls after.
REQ-034 tready=0 for 5 cycles mid-line -> tdata/tlast frozen, no pixel lost or duplicated.
REQ-035 LINE_LENGTH=16, 20 pixels then lineCaptured -> 16 beats streamed, tlast on the 16th, pixels 17..20 absent.
REQ-036 tready=0, three 8-pixel lines back to back -> lines 1 and 2 buffered, line 3 dropped, droppedLines=1; after tready=1, lines 1 then 2 streamed in order.
REQ-037 lineCaptured with no pixels, then enable low mid-line -> no stream output, droppedLines unchanged, next full line streams correctly.
REQ-038 Assert reset during R_STREAM -> next cycle tvalid=0, busy=0, droppedLines=0; a subsequent line streams from bank A.
